inst_fetch_queue: RTL

Decoupling FIFO between the program counter / instruction memory and the decode stage of the uniprocessor. Each entry holds one fetched instruction together with the address it was fetched from. Decode stalls therefore do not back-pressure instruction memory for up to DEPTH instructions. A flush input discards all in-flight entries on a taken branch or jump.

---
 rtl/inst_fetch_queue.sv | 99 +++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, inst, misalign} decoupling fetch from decode.
// Optional misaligned-address tagging is enabled with `define IFQ_MISALIGN_CHK_EN.
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_pc,
    input  logic [INST_W-1:0] f_inst,
    output logic              f_ready,
    output logic              d_valid,
    output logic [ADDR_W-1:0] d_pc,
    output logic [INST_W-1:0] d_inst,
    output logic              d_misalign,
    input  logic              d_ready,
    output logic [LVL_W-1:0]  level
);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Handshake side: no ready-through and no bypass, so neither ready nor
    // valid depends combinationally on the opposite side of the queue.
    always_comb begin
        f_ready = rstn && !flush && (cnt != LVL_W'(DEPTH));
        d_valid = !flush && (cnt != '0);
        push    = f_valid && f_ready;
        pop     = d_valid && d_ready;
        level   = cnt;
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is data-only and deliberately left out of reset.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= f_pc;
            inst_mem[wr_ptr] <= f_inst;
        end
    end

    always_comb begin
        d_pc   = '0;
        d_inst = '0;
        if (d_valid) begin
            d_pc   = pc_mem[rd_ptr];
            d_inst = inst_mem[rd_ptr];
        end
    end

`ifdef IFQ_MISALIGN_CHK_EN
    logic mis_mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mis_mem[wr_ptr] <= (f_pc[1:0] != 2'b00);
        end
    end

    assign d_misalign = d_valid && mis_mem[rd_ptr];
`else
    assign d_misalign = 1'b0;
`endif

endmodule
